// File: rtl/fft_consts.sv
// Shared FFT frame constants, unloader state encoding and the address bit-reversal helper.
package fft_consts;

  localparam int N          = 16;
  localparam int LOG2N      = 4;
  localparam int DW_COMPLEX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } unload_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stream_fifo.sv
// Synchronous FIFO with head-of-queue output; push and pop together are legal even when full.
module fft_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Storage is not reset, so the head is masked to keep the output at zero when empty.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (!do_push && do_pop) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fft_output_unloader.sv
// Reads a finished FFT frame out of RAM port B and streams it on valid/ready,
// issuing reads only while FIFO occupancy plus in-flight reads leaves room.
module fft_output_unloader
  import fft_consts::*;
#(
  parameter int BITREV     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [LOG2N-1:0]      ram_addrb,
  output logic [DW_COMPLEX-1:0] ram_dinb,
  input  logic [DW_COMPLEX-1:0] ram_doutb,
  output logic [DW_COMPLEX-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [LOG2N:0]   IDX_ONE  = (LOG2N+1)'(1);
  localparam logic [LOG2N:0]   IDX_LAST = (LOG2N+1)'(N-1);
  localparam logic [LOG2N-1:0] OUT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] OUT_LAST = LOG2N'(N-1);
  localparam logic [CW+1:0]    CREDITS  = (CW+2)'(FIFO_DEPTH);

  unload_state_t     state_q;
  unload_state_t     state_d;
  logic [LOG2N:0]    rd_idx;
  logic              rd_vld;
  logic [LOG2N-1:0]  out_idx;
  logic [CW:0]       occ;
  logic [CW+1:0]     pending;
  logic              fifo_full;
  logic              fifo_empty;
  logic              credit_ok;
  logic              hs;

  // rd_vld marks the read issued last cycle whose data is on ram_doutb now.
  assign pending   = {1'b0, occ} + {{(CW+1){1'b0}}, rd_vld};
  assign credit_ok = !fifo_full && (pending < CREDITS);
  assign m_valid   = !fifo_empty;
  assign hs        = m_valid && m_ready;
  assign m_last    = m_valid && (out_idx == OUT_LAST);
  assign busy      = (state_q != ST_IDLE);
  assign ram_web   = 1'b0;
  assign ram_dinb  = '0;

  always_comb begin
    if (BITREV != 0) ram_addrb = bitrev(rd_idx[LOG2N-1:0]);
    else             ram_addrb = rd_idx[LOG2N-1:0];
  end

  always_comb begin
    state_d = state_q;
    ram_enb = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (credit_ok) begin
          ram_enb = 1'b1;
          if (rd_idx == IDX_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hs && m_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_idx  <= '0;
      rd_vld  <= 1'b0;
      out_idx <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_vld  <= ram_enb;
      done    <= (state_q == ST_DRAIN) && hs && m_last;
      if (state_q == ST_IDLE && start) begin
        rd_idx  <= '0;
        out_idx <= '0;
      end else begin
        if (ram_enb) rd_idx  <= rd_idx + IDX_ONE;
        if (hs)      out_idx <= out_idx + OUT_ONE;
      end
    end
  end

  fft_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW_COMPLEX)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_vld),
    .push_data (ram_doutb),
    .pop       (hs),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ)
  );

endmodule

// File: tb/tb_fft_output_unloader.sv
// Directed bench: natural and bit-reversed unload, back-pressure, mid-frame reset, start re-pulse.
module tb_fft_output_unloader;
  import fft_consts::*;

  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                  start0 = 1'b0, busy0, done0, enb0, web0, valid0, ready0 = 1'b1, last0;
  logic [LOG2N-1:0]      addr0;
  logic [DW_COMPLEX-1:0] dinb0, data0;
  logic [DW_COMPLEX-1:0] doutb0 = '0;

  logic                  start1 = 1'b0, busy1, done1, enb1, web1, valid1, ready1 = 1'b1, last1;
  logic [LOG2N-1:0]      addr1;
  logic [DW_COMPLEX-1:0] dinb1, data1;
  logic [DW_COMPLEX-1:0] doutb1 = '0;

  logic [DW_COMPLEX-1:0] mem [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_output_unloader #(.BITREV(0), .FIFO_DEPTH(FD)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .ram_enb(enb0), .ram_web(web0), .ram_addrb(addr0), .ram_dinb(dinb0),
    .ram_doutb(doutb0), .m_data(data0), .m_valid(valid0), .m_ready(ready0),
    .m_last(last0)
  );

  fft_output_unloader #(.BITREV(1), .FIFO_DEPTH(FD)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .ram_enb(enb1), .ram_web(web1), .ram_addrb(addr1), .ram_dinb(dinb1),
    .ram_doutb(doutb1), .m_data(data1), .m_valid(valid1), .m_ready(ready1),
    .m_last(last1)
  );

  // One-cycle read latency RAM port B for each instance.
  always @(posedge clk) if (enb0) doutb0 <= mem[addr0];
  always @(posedge clk) if (enb1) doutb1 <= mem[addr1];

  function automatic logic [DW_COMPLEX-1:0] word(input int k);
    logic [15:0] r;
    r = k[15:0];
    return {r, ~r};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: ready high, cycle-exact checks; 1: random ready; 2: ready low 20 cycles;
  // 3: ready high with start re-pulsed in cycle 5. abort_at >= 0 resets after that sample.
  task automatic frame0(input string tag, input int mode, input int abort_at);
    int got = 0;
    int enb_cnt = 0;
    int outstanding = 0;
    int dones = 0;
    int done_c = -1;
    logic stalled = 1'b0;
    logic [DW_COMPLEX-1:0] held = '0;
    logic hs;
    @(negedge clk);
    start0 = 1'b1;
    ready0 = (mode == 2) ? 1'b0 : 1'b1;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      start0 = (mode == 3 && c == 5);
      case (mode)
        1:       ready0 = 1'($urandom_range(0, 1));
        2:       ready0 = (c > 20);
        default: ready0 = 1'b1;
      endcase
      hs = valid0 && ready0;
      if (mode == 0) begin
        check_eq({tag, ":valid"}, valid0, (c >= 3 && c <= N + 2));
        check_eq({tag, ":busy"}, busy0, (c <= N + 2));
        check_eq({tag, ":done"}, done0, (c == N + 3));
        if (c == 1) begin
          check_eq({tag, ":first_enb"}, enb0, 1);
          check_eq({tag, ":first_addr"}, addr0, 0);
        end
      end
      if (mode == 2 && c == 20) begin
        check_eq({tag, ":reads_while_blocked"}, enb_cnt, FD);
        check_eq({tag, ":enb_blocked"}, enb0, 0);
      end
      if (enb0) begin
        check_eq({tag, ":credit"}, outstanding < FD, 1);
        enb_cnt++;
      end
      if (stalled) begin
        check_eq({tag, ":hold_valid"}, valid0, 1);
        check_eq({tag, ":hold_data"}, data0, held);
      end
      if (valid0) check_eq({tag, ":last"}, last0, (got == N - 1));
      if (done0) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
      if (hs) begin
        check_eq({tag, ":data"}, data0, word(got));
        got++;
      end
      outstanding = outstanding + int'(enb0) - int'(hs);
      stalled = valid0 && !ready0;
      held = data0;
      if (abort_at >= 0 && hs && got == abort_at + 1) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq({tag, ":rst_busy"}, busy0, 0);
        check_eq({tag, ":rst_valid"}, valid0, 0);
        check_eq({tag, ":rst_data"}, data0, 0);
        check_eq({tag, ":rst_last"}, last0, 0);
        check_eq({tag, ":rst_enb"}, enb0, 0);
        check_eq({tag, ":rst_done"}, done0, 0);
        return;
      end
      if (done_c >= 0 && c >= done_c + 5) break;
    end
    check_eq({tag, ":samples"}, got, N);
    check_eq({tag, ":reads"}, enb_cnt, N);
    check_eq({tag, ":done_pulses"}, dones, 1);
    check_eq({tag, ":idle_busy"}, busy0, 0);
  endtask

  logic [LOG2N-1:0] br_order [N];

  initial begin
    br_order = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int k = 0; k < N; k++) mem[k] = word(k);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset:busy", busy0, 0);
    check_eq("reset:done", done0, 0);
    check_eq("reset:enb", enb0, 0);
    check_eq("reset:addr", addr0, 0);
    check_eq("reset:valid", valid0, 0);
    check_eq("reset:last", last0, 0);
    check_eq("reset:data", data0, 0);
    check_eq("reset:web", web0, 0);
    check_eq("reset:dinb", dinb0, 0);
    check_eq("reset:valid_br", valid1, 0);

    frame0("nat", 0, -1);

    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      check_eq("br:valid", valid1, (c >= 3 && c <= N + 2));
      check_eq("br:done", done1, (c == N + 3));
      if (c >= 3 && c <= N + 2) begin
        check_eq("br:data", data1, word(int'(br_order[c - 3])));
        check_eq("br:last", last1, (c == N + 2));
      end
    end

    frame0("rand", 1, -1);
    frame0("blocked", 2, -1);
    frame0("abort", 0, 5);
    frame0("restart", 0, -1);
    frame0("repulse", 3, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
